baseball_play_ctrl: RTL and testbench
=====================================

Name: baseball_play_ctrl

Overview:
Game-state controller that drives the scoreboard display block's inputs: team, base[2:0] and add_to_score[3:0]. It converts five operator push-button events (single, double, triple, home run, out) into runner advancement, run pulses, out counting, half-inning changes and an inning counter. It sits between the board buttons and the scoreboard LED/7-segment output block. It holds no scores; the display block accumulates them.

Parameters:
INNINGS, 9, number of full innings; game ends after the bottom half of this inning.
MAX_OUTS, 3, outs per half-inning.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous reset, active-low
btn_single  input  1  single button, active-high, externally debounced, asynchronous to clk
btn_double  input  1  double button, same format
btn_triple  input  1  triple button, same format
btn_homer  input  1  home-run button, same format
btn_out  input  1  out button, same format
team  output  1  batting team: 0 = visitors (top half), 1 = home (bottom half)
base  output  3  occupancy: base[2] = first, base[1] = second, base[0] = third; 1 = runner present
add_to_score  output  4  one-cycle one-hot run pulse: bit0 = 1 run, bit1 = 2, bit2 = 3, bit3 = 4; 0 = none
outs  output  2  outs in current half-inning, 0..MAX_OUTS-1
inning  output  4  current inning, 1..INNINGS
game_over  output  1  high once the game has ended

Behaviour:
- Reset is asynchronous, active-low; clock is clk. While reset_n = 0: team=0, base=000, add_to_score=0000, outs=0, inning=1, game_over=0, FSM=PLAY, synchroniser and edge registers cleared.
- Input path per button: 2-FF synchroniser, then a previous-value register. An event is sync2 & ~prev.
  - Outputs update on the 3rd rising clk edge after the input is first sampled high.
  - A held button produces one event; release produces none.
- Simultaneous events: if more than one button produces an event in the same cycle, all of them are discarded and state is unchanged.
- FSM states: PLAY and GAME_OVER. GAME_OVER is left only by reset; all events are ignored in GAME_OVER and outputs hold.
- Runner advancement in PLAY, with r1/r2/r3 = first/second/third before the event:
  - single: runs = r3; new state third=r2, second=r1, first=1.
  - double: runs = r2+r3; third=r1, second=1, first=0.
  - triple: runs = r1+r2+r3; third=1, second=0, first=0.
  - homer: runs = r1+r2+r3+1; all bases cleared.
  - out: runs = 0; bases unchanged unless this is the third out.
- Run pulse: runs = 0 gives add_to_score = 0000; runs 1..4 give one-hot bit runs-1.
  - The pulse is registered and high for exactly one cycle, the same cycle base updates.
  - team is unchanged in that cycle, so the display credits the correct team.
  - A following event in the next cycle may raise a new pulse back-to-back.
- Out handling:
  - If outs < MAX_OUTS-1: outs += 1.
  - Otherwise (side retired), in the same cycle: outs=0, base=000, team toggles.
  - If team was 1 (bottom half ends) and inning < INNINGS: inning += 1.
  - If team was 1 and inning == INNINGS: go to GAME_OVER, game_over=1, team stays 1, inning stays INNINGS, base=000, outs=0.
- No walk-off, skip-bottom or extra-inning logic, because scores are not visible here. inning never wraps.
- add_to_score is forced to 0 in any cycle without a valid scoring event.

Decomposition:
- Package baseball_pkg holds:
  - event encoding (EV_NONE, EV_SINGLE, EV_DOUBLE, EV_TRIPLE, EV_HOMER, EV_OUT)
  - base bit-index constants (BASE_1ST=2, BASE_2ND=1, BASE_3RD=0)
  - run one-hot constants (RUN1..RUN4)
  - team constants (TEAM_VISITOR=0, TEAM_HOME=1)
  - default MAX_OUTS
- One sub-module, baseball_btn_sync: 2-FF synchroniser plus rising-edge detector, single-bit, instantiated five times.
- Advancement and run count are a pure function inside baseball_play_ctrl.

Test Plan:
- Reset mid-game: with bases 111, outs=2, inning=4, assert reset_n low asynchronously -> all outputs at reset values immediately, with no clk edge required.
- Bases empty, then single, single, double -> base 100, then 110, then 011 with add_to_score=0001 for one cycle on the double; team=0 throughout.
- Bases loaded (111), then homer -> add_to_score=1000 for one cycle, base=000; the next cycle has add_to_score=0000.
- From team=0, outs=0, bases 101: three out presses -> outs goes 1, then 2, then on the third out outs=0, base=000, team=1, inning still 1. Three more outs -> team=0, inning=2.
- btn_single and btn_out rising in the same cycle -> no state change and no pulse. Holding btn_double high for 50 cycles -> exactly one event.
- Play to the bottom of inning INNINGS=2 (override), then the third out -> game_over=1, team=1, inning=2. Subsequent homer press -> no change, add_to_score stays 0000.

Source files
------------

// File: rtl/baseball_pkg.sv
// Shared encodings for the baseball play controller: button events, base bit
// positions, run pulse codes, team identifiers and FSM states.
package baseball_pkg;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_SINGLE,
    EV_DOUBLE,
    EV_TRIPLE,
    EV_HOMER,
    EV_OUT
  } event_e;

  typedef enum logic {
    ST_PLAY,
    ST_GAME_OVER
  } state_e;

  localparam int unsigned BASE_1ST = 2;
  localparam int unsigned BASE_2ND = 1;
  localparam int unsigned BASE_3RD = 0;

  localparam logic [3:0] RUN_NONE = 4'b0000;
  localparam logic [3:0] RUN1     = 4'b0001;
  localparam logic [3:0] RUN2     = 4'b0010;
  localparam logic [3:0] RUN3     = 4'b0100;
  localparam logic [3:0] RUN4     = 4'b1000;

  localparam logic TEAM_VISITOR = 1'b0;
  localparam logic TEAM_HOME    = 1'b1;

  localparam int unsigned DEF_MAX_OUTS = 3;

  typedef struct packed {
    logic [2:0] base;
    logic [2:0] runs;
  } advance_t;

  function automatic logic [3:0] run_onehot(input logic [2:0] runs);
    logic [3:0] code;
    code = RUN_NONE;
    case (runs)
      3'd1:    code = RUN1;
      3'd2:    code = RUN2;
      3'd3:    code = RUN3;
      3'd4:    code = RUN4;
      default: code = RUN_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/baseball_btn_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one
// asynchronous, externally debounced push-button.
module baseball_btn_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/baseball_play_ctrl.sv
// Game-state controller: turns operator button events into runner advancement,
// run pulses, out counting, half-inning changes and the inning count.
module baseball_play_ctrl
  import baseball_pkg::*;
#(
  parameter int unsigned INNINGS  = 9,
  parameter int unsigned MAX_OUTS = DEF_MAX_OUTS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_single,
  input  logic       btn_double,
  input  logic       btn_triple,
  input  logic       btn_homer,
  input  logic       btn_out,
  output logic       team,
  output logic [2:0] base,
  output logic [3:0] add_to_score,
  output logic [1:0] outs,
  output logic [3:0] inning,
  output logic       game_over
);

  localparam logic [1:0] LAST_OUT    = 2'(MAX_OUTS - 1);
  localparam logic [3:0] LAST_INNING = 4'(INNINGS);

  logic [4:0] btn_raw;
  logic [4:0] btn_evt;
  event_e     ev;

  state_e     state, state_nx;
  logic       team_nx;
  logic [2:0] base_nx;
  logic [3:0] add_nx;
  logic [1:0] outs_nx;
  logic [3:0] inning_nx;
  advance_t   adv;

  assign btn_raw = {btn_out, btn_homer, btn_triple, btn_double, btn_single};

  for (genvar i = 0; i < 5; i++) begin : g_sync
    baseball_btn_sync u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .btn    (btn_raw[i]),
      .pulse  (btn_evt[i])
    );
  end

  // Only a lone event is honoured; any coincident pair collapses to EV_NONE.
  always_comb begin
    ev = EV_NONE;
    case (btn_evt)
      5'b00001: ev = EV_SINGLE;
      5'b00010: ev = EV_DOUBLE;
      5'b00100: ev = EV_TRIPLE;
      5'b01000: ev = EV_HOMER;
      5'b10000: ev = EV_OUT;
      default:  ev = EV_NONE;
    endcase
  end

  function automatic advance_t advance(input event_e e, input logic [2:0] b);
    advance_t   a;
    logic [2:0] r1, r2, r3;
    r1     = {2'b00, b[BASE_1ST]};
    r2     = {2'b00, b[BASE_2ND]};
    r3     = {2'b00, b[BASE_3RD]};
    a.base = b;
    a.runs = '0;
    case (e)
      EV_SINGLE: begin
        a.runs           = r3;
        a.base[BASE_3RD] = b[BASE_2ND];
        a.base[BASE_2ND] = b[BASE_1ST];
        a.base[BASE_1ST] = 1'b1;
      end
      EV_DOUBLE: begin
        a.runs           = r2 + r3;
        a.base[BASE_3RD] = b[BASE_1ST];
        a.base[BASE_2ND] = 1'b1;
        a.base[BASE_1ST] = 1'b0;
      end
      EV_TRIPLE: begin
        a.runs = r1 + r2 + r3;
        a.base = 3'b000;
        a.base[BASE_3RD] = 1'b1;
      end
      EV_HOMER: begin
        a.runs = r1 + r2 + r3 + 3'd1;
        a.base = 3'b000;
      end
      default: begin
        a.runs = '0;
        a.base = b;
      end
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_PLAY;
      team         <= TEAM_VISITOR;
      base         <= '0;
      add_to_score <= '0;
      outs         <= '0;
      inning       <= 4'd1;
    end else begin
      state        <= state_nx;
      team         <= team_nx;
      base         <= base_nx;
      add_to_score <= add_nx;
      outs         <= outs_nx;
      inning       <= inning_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    team_nx   = team;
    base_nx   = base;
    add_nx    = '0;
    outs_nx   = outs;
    inning_nx = inning;
    adv       = advance(ev, base);

    case (state)
      ST_PLAY: begin
        if (ev == EV_OUT) begin
          if (outs < LAST_OUT) begin
            outs_nx = outs + 2'd1;
          end else begin
            outs_nx = '0;
            base_nx = '0;
            // The final bottom half ends the game with the home side still shown.
            if (team == TEAM_HOME && inning >= LAST_INNING) begin
              state_nx = ST_GAME_OVER;
            end else begin
              team_nx = ~team;
              if (team == TEAM_HOME) begin
                inning_nx = inning + 4'd1;
              end
            end
          end
        end else if (ev != EV_NONE) begin
          base_nx = adv.base;
          add_nx  = run_onehot(adv.runs);
        end
      end
      ST_GAME_OVER: begin
        state_nx = ST_GAME_OVER;
      end
      default: begin
        state_nx = ST_PLAY;
      end
    endcase
  end

  assign game_over = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_baseball_play_ctrl.sv
// Directed bench for baseball_play_ctrl with hand-computed expected values,
// run with a two-inning game.
module tb_baseball_play_ctrl;

  localparam int B_SINGLE = 0;
  localparam int B_DOUBLE = 1;
  localparam int B_TRIPLE = 2;
  localparam int B_HOMER  = 3;
  localparam int B_OUT    = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] btns = '0;
  logic       team;
  logic [2:0] base;
  logic [3:0] add_to_score;
  logic [1:0] outs;
  logic [3:0] inning;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;

  baseball_play_ctrl #(.INNINGS(2), .MAX_OUTS(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_single  (btns[B_SINGLE]),
    .btn_double  (btns[B_DOUBLE]),
    .btn_triple  (btns[B_TRIPLE]),
    .btn_homer   (btns[B_HOMER]),
    .btn_out     (btns[B_OUT]),
    .team        (team),
    .base        (base),
    .add_to_score(add_to_score),
    .outs        (outs),
    .inning      (inning),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise a button at a falling edge; the result is visible just after the
  // third rising edge.
  task automatic press(input int b);
    @(negedge clk);
    btns[b] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_btns;
    @(negedge clk);
    btns = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic hit(input int b, input string tag, input logic [2:0] exp_base, input logic [3:0] exp_add);
    press(b);
    check_eq({tag, "_base"}, 32'(base), 32'(exp_base));
    check_eq({tag, "_add"}, 32'(add_to_score), 32'(exp_add));
    @(posedge clk);
    #1;
    check_eq({tag, "_add_next"}, 32'(add_to_score), 32'd0);
    release_btns();
  endtask

  task automatic out_press(input string tag, input logic [1:0] exp_outs, input logic exp_team,
                           input logic [3:0] exp_inning);
    press(B_OUT);
    check_eq({tag, "_outs"}, 32'(outs), 32'(exp_outs));
    check_eq({tag, "_team"}, 32'(team), 32'(exp_team));
    check_eq({tag, "_inning"}, 32'(inning), 32'(exp_inning));
    check_eq({tag, "_add"}, 32'(add_to_score), 32'd0);
    release_btns();
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_team"}, 32'(team), 32'd0);
    check_eq({tag, "_base"}, 32'(base), 32'd0);
    check_eq({tag, "_add"}, 32'(add_to_score), 32'd0);
    check_eq({tag, "_outs"}, 32'(outs), 32'd0);
    check_eq({tag, "_inning"}, 32'(inning), 32'd1);
    check_eq({tag, "_go"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Runner advancement from empty bases.
    hit(B_SINGLE, "s1", 3'b100, 4'b0000);
    hit(B_SINGLE, "s2", 3'b110, 4'b0000);
    hit(B_DOUBLE, "d1", 3'b011, 4'b0001);
    check_eq("team_top", 32'(team), 32'd0);

    // Load the bases, then a grand slam.
    hit(B_SINGLE, "s3", 3'b101, 4'b0001);
    hit(B_SINGLE, "s4", 3'b110, 4'b0001);
    hit(B_SINGLE, "s5", 3'b111, 4'b0000);
    hit(B_HOMER, "hr4", 3'b000, 4'b1000);

    // Set up 101 and retire both halves of inning 1.
    hit(B_DOUBLE, "d2", 3'b010, 4'b0000);
    hit(B_SINGLE, "s6", 3'b101, 4'b0000);
    out_press("o1", 2'd1, 1'b0, 4'd1);
    check_eq("o1_base", 32'(base), 32'b101);
    out_press("o2", 2'd2, 1'b0, 4'd1);
    out_press("o3", 2'd0, 1'b1, 4'd1);
    check_eq("o3_base", 32'(base), 32'b000);
    out_press("o4", 2'd1, 1'b1, 4'd1);
    out_press("o5", 2'd2, 1'b1, 4'd1);
    out_press("o6", 2'd0, 1'b0, 4'd2);

    // Coincident single and out are both dropped.
    @(negedge clk);
    btns[B_SINGLE] = 1'b1;
    btns[B_OUT]    = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (add_to_score != 4'b0000) pulses++;
    end
    check_eq("simul_base", 32'(base), 32'd0);
    check_eq("simul_outs", 32'(outs), 32'd0);
    check_eq("simul_pulses", 32'(pulses), 32'd0);
    release_btns();

    // A held double counts once: a second double from 011 would score two.
    hit(B_SINGLE, "s7", 3'b100, 4'b0000);
    press(B_DOUBLE);
    check_eq("hold_base0", 32'(base), 32'b011);
    pulses = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (add_to_score != 4'b0000) pulses++;
    end
    check_eq("hold_base", 32'(base), 32'b011);
    check_eq("hold_pulses", 32'(pulses), 32'd0);
    release_btns();

    // Asynchronous reset mid-game.
    hit(B_SINGLE, "s8", 3'b101, 4'b0001);
    hit(B_SINGLE, "s9", 3'b110, 4'b0001);
    hit(B_SINGLE, "s10", 3'b111, 4'b0000);
    out_press("o7", 2'd1, 1'b0, 4'd2);
    out_press("o8", 2'd2, 1'b0, 4'd2);
    check_eq("pre_rst_base", 32'(base), 32'b111);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals("arst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Play out to the bottom of inning 2, then end the game.
    for (int unsigned i = 0; i < 9; i++) begin
      press(B_OUT);
      release_btns();
    end
    check_eq("bot2_team", 32'(team), 32'd1);
    check_eq("bot2_inning", 32'(inning), 32'd2);
    hit(B_SINGLE, "s11", 3'b100, 4'b0000);
    out_press("o9", 2'd1, 1'b1, 4'd2);
    out_press("o10", 2'd2, 1'b1, 4'd2);
    check_eq("pre_go", 32'(game_over), 32'd0);
    out_press("o11", 2'd0, 1'b1, 4'd2);
    check_eq("go", 32'(game_over), 32'd1);
    check_eq("go_base", 32'(base), 32'd0);
    hit(B_HOMER, "go_hr", 3'b000, 4'b0000);
    check_eq("go_hold", 32'(game_over), 32'd1);
    check_eq("go_team", 32'(team), 32'd1);
    check_eq("go_inning", 32'(inning), 32'd2);
    check_eq("go_outs", 32'(outs), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
